// File: rtl/rf_wb_arbiter_if.sv
// Register-file writeback bus: two writeback request channels (A = ALU,
// M = memory), the issue/hazard query port, the register-file write drive
// and the pending-write scoreboard vector.
//
// Handshake: a channel transfers in a cycle where its vld and rdy are both
// high. rdy is combinational from vld and arbitration state, and at most one
// rdy is high per cycle. The requester holds adr/data stable while vld is high.
interface rf_wb_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 16
);
  logic              a_vld;
  logic              a_rdy;
  logic [AW-1:0]     a_adr;
  logic [DW-1:0]     a_data;
  logic              m_vld;
  logic              m_rdy;
  logic [AW-1:0]     m_adr;
  logic [DW-1:0]     m_data;
  logic              iss_vld;
  logic [AW-1:0]     iss_adr;
  logic [AW-1:0]     rd_adr1;
  logic [AW-1:0]     rd_adr2;
  logic              stall;
  logic              writeEn;
  logic [AW-1:0]     writeAdr;
  logic [DW-1:0]     writeData;
  logic [(1<<AW)-1:0] busy;

  modport master (
    output a_vld, a_adr, a_data, m_vld, m_adr, m_data,
    output iss_vld, iss_adr, rd_adr1, rd_adr2,
    input  a_rdy, m_rdy, stall, writeEn, writeAdr, writeData, busy
  );

  modport slave (
    input  a_vld, a_adr, a_data, m_vld, m_adr, m_data,
    input  iss_vld, iss_adr, rd_adr1, rd_adr2,
    output a_rdy, m_rdy, stall, writeEn, writeAdr, writeData, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with a pending-write scoreboard.
// Two writeback channels (A, M) compete for one register-file write port;
// the granted request is written one cycle later. A busy bit per register
// tracks issued-but-not-written-back destinations and drives the issue stall.
// Optional macro RF_WB_RR_EN: round-robin arbitration between A and M.
// Without it, M has fixed priority and no pointer state exists.
module rf_wb_arbiter #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic clk,
  input  logic rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int NR = 1 << AW;

  logic          aGrant;
  logic          mGrant;
  logic          xfer;
  logic [AW-1:0] xferAdr;
  logic [DW-1:0] xferData;
  logic          issueOk;
  logic          stallInt;
  logic [NR-1:0] busyQ;
  logic [NR-1:0] busyNext;
  logic          writeEnQ;
  logic [AW-1:0] writeAdrQ;
  logic [DW-1:0] writeDataQ;

`ifdef RF_WB_RR_EN
  // lastGrantA = 1 means A was granted most recently, so M wins the next
  // conflict; reset value makes M win the first conflict.
  logic lastGrantA;

  // Pointer follows every transfer, including writes to register 0.
  always_ff @(posedge clk) begin
    if (rst) lastGrantA <= 1'b1;
    else if (xfer) lastGrantA <= aGrant;
  end

  // Round-robin grant: on conflict, the channel not granted most recently.
  always_comb begin
    aGrant = 1'b0;
    mGrant = 1'b0;
    if (!rst) begin
      if (bus.a_vld && bus.m_vld) begin
        mGrant = lastGrantA;
        aGrant = !lastGrantA;
      end else begin
        aGrant = bus.a_vld;
        mGrant = bus.m_vld;
      end
    end
  end
`else
  // Fixed-priority grant: M always wins a conflict.
  always_comb begin
    aGrant = 1'b0;
    mGrant = 1'b0;
    if (!rst) begin
      mGrant = bus.m_vld;
      aGrant = bus.a_vld && !bus.m_vld;
    end
  end
`endif

  assign bus.a_rdy = aGrant;
  assign bus.m_rdy = mGrant;
  assign xfer      = aGrant || mGrant;

  // Mux the granted request onto the write path.
  always_comb begin
    xferAdr  = bus.m_adr;
    xferData = bus.m_data;
    if (aGrant) begin
      xferAdr  = bus.a_adr;
      xferData = bus.a_data;
    end
  end

  // RAW hazards on either source plus WAW on the destination; nothing stalls in reset.
  assign stallInt = !rst && (busyQ[bus.rd_adr1] || busyQ[bus.rd_adr2] ||
                             (bus.iss_vld && busyQ[bus.iss_adr]));
  assign bus.stall = stallInt;
  assign issueOk   = bus.iss_vld && !stallInt && !rst;

  // Scoreboard update: writeback clears, accepted issue sets, set wins; reg 0 never busy.
  always_comb begin
    busyNext = busyQ;
    if (xfer && (xferAdr != '0)) busyNext[xferAdr] = 1'b0;
    if (issueOk && (bus.iss_adr != '0)) busyNext[bus.iss_adr] = 1'b1;
    busyNext[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busyQ <= '0;
    else busyQ <= busyNext;
  end

  assign bus.busy = rst ? '0 : busyQ;

  // Registered write port: one-cycle pulse per non-zero transfer; address and
  // data hold when nothing is written (a register-0 transfer writes nothing).
  always_ff @(posedge clk) begin
    if (rst) begin
      writeEnQ   <= 1'b0;
      writeAdrQ  <= '0;
      writeDataQ <= '0;
    end else begin
      writeEnQ <= xfer && (xferAdr != '0);
      if (xfer && (xferAdr != '0)) begin
        writeAdrQ  <= xferAdr;
        writeDataQ <= xferData;
      end
    end
  end

  assign bus.writeEn   = writeEnQ;
  assign bus.writeAdr  = writeAdrQ;
  assign bus.writeData = writeDataQ;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: a directed cycle table followed by random
// traffic checked against a behavioural model of the arbiter and scoreboard.
module tb_rf_wb_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   failed;

`ifdef RF_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  rf_wb_arbiter_if #(.AW(4), .DW(16)) bus ();

  rf_wb_arbiter #(.AW(4), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit        av;
    bit [3:0]  aa;
    bit [15:0] ad;
    bit        mv;
    bit [3:0]  ma;
    bit [15:0] md;
    bit        iv;
    bit [3:0]  ia;
    bit [3:0]  r1;
    bit [3:0]  r2;
    bit        ea;
    bit        em;
    bit        es;
    bit        ewe;
    bit [3:0]  ewa;
    bit [15:0] ewd;
    bit        cw;
    bit [15:0] eb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input bit rs, input bit av, input bit [3:0] aa, input bit [15:0] ad,
    input bit mv, input bit [3:0] ma, input bit [15:0] md,
    input bit iv, input bit [3:0] ia, input bit [3:0] r1, input bit [3:0] r2,
    input bit ea, input bit em, input bit es,
    input bit ewe, input bit [3:0] ewa, input bit [15:0] ewd, input bit cw,
    input bit [15:0] eb);
    vec_t v;
    v.rst = rs; v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv; v.ma = ma; v.md = md;
    v.iv = iv; v.ia = ia; v.r1 = r1; v.r2 = r2;
    v.ea = ea; v.em = em; v.es = es;
    v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.cw = cw; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: put one cycle of stimulus on the bus
  task automatic drive(input bit rs, input bit av, input bit [3:0] aa, input bit [15:0] ad,
                       input bit mv, input bit [3:0] ma, input bit [15:0] md,
                       input bit iv, input bit [3:0] ia, input bit [3:0] r1, input bit [3:0] r2);
    rst = rs;
    bus.a_vld = av; bus.a_adr = aa; bus.a_data = ad;
    bus.m_vld = mv; bus.m_adr = ma; bus.m_data = md;
    bus.iss_vld = iv; bus.iss_adr = ia;
    bus.rd_adr1 = r1; bus.rd_adr2 = r2;
  endtask

  // behavioural model state
  bit        mb[16];
  bit        mWe;
  bit [3:0]  mWa;
  bit [15:0] mWd;
  bit        mKnown;
  bit        mLastA;
  logic [15:0] exp_q[$];

  function automatic bit [15:0] busy_vec();
    bit [15:0] b;
    for (int i = 0; i < 16; i++) b[i] = mb[i];
    return b;
  endfunction

  task automatic rand_cycle(input int n, input bit forceRst);
    bit rs, av, mv, iv;
    bit [3:0] aa, ma, ia, r1, r2;
    bit [15:0] ad, md;
    bit ga, gm, st;
    rs = forceRst || ($urandom_range(0, 49) == 0);
    av = $urandom_range(0, 1); mv = $urandom_range(0, 1); iv = $urandom_range(0, 1);
    aa = 4'($urandom_range(0, 7)); ma = 4'($urandom_range(0, 7));
    ia = 4'($urandom_range(0, 7));
    r1 = 4'($urandom_range(0, 7)); r2 = 4'($urandom_range(0, 15));
    ad = 16'($urandom); md = 16'($urandom);
    drive(rs, av, aa, ad, mv, ma, md, iv, ia, r1, r2);
    // who should win this cycle
    ga = 0; gm = 0;
    if (!rs) begin
      if (av && mv) begin
        if (RR) begin gm = mLastA; ga = !mLastA; end
        else gm = 1;
      end else begin
        ga = av; gm = mv;
      end
    end
    st = !rs && (mb[r1] || mb[r2] || (iv && mb[ia]));
    #1;
    chk($sformatf("rnd%0d a_rdy", n), bus.a_rdy, ga);
    chk($sformatf("rnd%0d m_rdy", n), bus.m_rdy, gm);
    chk($sformatf("rnd%0d stall", n), bus.stall, st);
    // next model state
    if (rs) begin
      foreach (mb[i]) mb[i] = 0;
      mWe = 0; mWa = 0; mWd = 0; mKnown = 1; mLastA = 1;
    end else begin
      mWe = 0;
      if (ga || gm) begin
        bit [3:0] adr;
        bit [15:0] dat;
        adr = ga ? aa : ma;
        dat = ga ? ad : md;
        mLastA = ga;
        if (adr != 0) begin
          mWe = 1; mWa = adr; mWd = dat; mKnown = 1;
          mb[adr] = 0;
        end else begin
          mKnown = 0;
        end
      end
      if (iv && !st && ia != 0) mb[ia] = 1;
    end
    exp_q.push_back(busy_vec());
    @(posedge clk); #1;
    chk($sformatf("rnd%0d writeEn", n), bus.writeEn, mWe);
    chk($sformatf("rnd%0d busy", n), bus.busy, exp_q.pop_front());
    if (mKnown) begin
      chk($sformatf("rnd%0d writeAdr", n), bus.writeAdr, mWa);
      chk($sformatf("rnd%0d writeData", n), bus.writeData, mWd);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //         rst av aa  ad       mv ma  md       iv ia r1 r2  ea   em   es  ewe ewa           ewd                     cw  eb
    vecs.push_back(mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 0,  0,   0,   0,  0,  0,            16'h0,                  1,  16'h0000));
    vecs.push_back(mk(0, 1, 3, 16'h1234, 0, 0, 16'h0,    0, 0, 0, 0,  1,   0,   0,  1,  3,            16'h1234,               1,  16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 0,  0,   0,   0,  0,  3,            16'h1234,               1,  16'h0000));
    vecs.push_back(mk(0, 1, 5, 16'h5555, 1, 6, 16'h6666, 0, 0, 0, 0,  0,   1,   0,  1,  6,            16'h6666,               1,  16'h0000));
    vecs.push_back(mk(0, 1, 5, 16'h5555, 1, 6, 16'h6666, 0, 0, 0, 0,  RR,  !RR, 0,  1,  RR ? 4'd5 : 4'd6, RR ? 16'h5555 : 16'h6666, 1,  16'h0000));
    vecs.push_back(mk(0, 1, 5, 16'h5555, 1, 6, 16'h6666, 0, 0, 0, 0,  0,   1,   0,  1,  6,            16'h6666,               1,  16'h0000));
    vecs.push_back(mk(0, 1, 5, 16'h5555, 1, 6, 16'h6666, 0, 0, 0, 0,  RR,  !RR, 0,  1,  RR ? 4'd5 : 4'd6, RR ? 16'h5555 : 16'h6666, 1,  16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 7, 0, 0,  0,   0,   0,  0,  0,            16'h0,                  0,  16'h0080));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 7, 0,  0,   0,   1,  0,  0,            16'h0,                  0,  16'h0080));
    vecs.push_back(mk(0, 0, 0, 16'h0,    1, 7, 16'h7777, 0, 0, 7, 0,  0,   1,   1,  1,  7,            16'h7777,               1,  16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 7, 0,  0,   0,   0,  0,  0,            16'h0,                  0,  16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0,    1, 4, 16'h4444, 1, 4, 0, 0,  0,   1,   0,  1,  4,            16'h4444,               1,  16'h0010));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 4, 0, 0,  0,   0,   1,  0,  0,            16'h0,                  0,  16'h0010));
    vecs.push_back(mk(0, 1, 0, 16'hFFFF, 0, 0, 16'h0,    0, 0, 0, 0,  1,   0,   0,  0,  0,            16'h0,                  0,  16'h0010));
    vecs.push_back(mk(0, 1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0, 0, 0,  0,   1,   0,  1,  2,            16'h2222,               1,  16'h0010));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 2, 0, 0,  0,   0,   0,  0,  0,            16'h0,                  0,  16'h0014));
    vecs.push_back(mk(0, 1, 9, 16'h9999, 0, 0, 16'h0,    0, 0, 0, 2,  1,   0,   1,  1,  9,            16'h9999,               1,  16'h0014));
    vecs.push_back(mk(1, 1, 9, 16'h9999, 0, 0, 16'h0,    0, 0, 2, 0,  0,   0,   0,  0,  0,            16'h0,                  1,  16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 2, 0,  0,   0,   0,  0,  0,            16'h0,                  0,  16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 0, 0, 0,  0,   0,   0,  0,  0,            16'h0,                  0,  16'h0000));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md,
            vecs[i].iv, vecs[i].ia, vecs[i].r1, vecs[i].r2);
      #1;
      chk($sformatf("vec%0d a_rdy", i), bus.a_rdy, vecs[i].ea);
      chk($sformatf("vec%0d m_rdy", i), bus.m_rdy, vecs[i].em);
      chk($sformatf("vec%0d stall", i), bus.stall, vecs[i].es);
      @(posedge clk); #1;
      chk($sformatf("vec%0d writeEn", i), bus.writeEn, vecs[i].ewe);
      chk($sformatf("vec%0d busy", i), bus.busy, vecs[i].eb);
      if (vecs[i].cw) begin
        chk($sformatf("vec%0d writeAdr", i), bus.writeAdr, vecs[i].ewa);
        chk($sformatf("vec%0d writeData", i), bus.writeData, vecs[i].ewd);
      end
    end

    // random traffic against the model, starting from a reset cycle
    for (int n = 0; n < 600; n++) rand_cycle(n, n == 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
